// File: rtl/iterative_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative shift-and-add multiplier.
package iterative_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic int mul_steps(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // Counter must be able to represent the full step count.
    function automatic int mul_cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/iterative_multiplier_if.sv
// Operand/product handshake bundle for the iterative multiplier.
interface iterative_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_product;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_product
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_product
    );
endinterface

// File: rtl/iterative_multiplier_step.sv
// One shift-and-add step: folds BITS_PER_CYCLE partial products into the accumulator.
module iterative_multiplier_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic [2*WIDTH-1:0]        acc_i,
    input  logic [2*WIDTH-1:0]        mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] mplier_bits_i,
    output logic [2*WIDTH-1:0]        acc_o
);

    logic [2*WIDTH-1:0] sum_s;

    // Add the multiplicand shifted by k for every set multiplier bit k
    always_comb begin
        sum_s = acc_i;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_bits_i[k]) begin
                sum_s = sum_s + (mcand_i << k);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    assign acc_o = sum_s;

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle double-width multiplier; define MUL_SIGNED_EN for two's-complement operands.
module iterative_multiplier
    import iterative_multiplier_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    iterative_multiplier_if.slave bus
);

    localparam int N  = mul_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CW = mul_cnt_width(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("iterative_multiplier: WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    mul_state_e          state_r;
    logic [2*WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]    mplier_r;
    logic [2*WIDTH-1:0]  acc_r;
    logic [CW-1:0]       cnt_r;
    logic                out_valid_r;
    logic [2*WIDTH-1:0]  out_product_r;

    logic                in_ready_s;
    logic                accept_s;
    logic [WIDTH-1:0]    load_a_s;
    logic [WIDTH-1:0]    load_b_s;
    logic [2*WIDTH-1:0]  acc_next_s;
    logic [2*WIDTH-1:0]  final_s;

`ifdef MUL_SIGNED_EN
    logic                neg_r;
    logic                load_neg_s;
`endif

    // DONE hands over to a new operand in the same cycle the product is taken.
    assign in_ready_s      = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
    assign accept_s        = bus.in_valid && in_ready_s;
    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_product = out_product_r;

    iterative_multiplier_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i         (acc_r),
        .mcand_i       (mcand_r),
        .mplier_bits_i (mplier_r[BITS_PER_CYCLE-1:0]),
        .acc_o         (acc_next_s)
    );

    // Operand magnitudes at accept and the sign-corrected result of the final step
    always_comb begin
`ifdef MUL_SIGNED_EN
        load_a_s   = bus.in_a[WIDTH-1] ? ({WIDTH{1'b0}} - bus.in_a) : bus.in_a;
        load_b_s   = bus.in_b[WIDTH-1] ? ({WIDTH{1'b0}} - bus.in_b) : bus.in_b;
        load_neg_s = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
        final_s    = neg_r ? ({(2*WIDTH){1'b0}} - acc_next_s) : acc_next_s;
`else
        load_a_s   = bus.in_a;
        load_b_s   = bus.in_b;
        final_s    = acc_next_s;
`endif
    end

    // Control FSM with operand/accumulator datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= IDLE;
            mcand_r       <= {(2*WIDTH){1'b0}};
            mplier_r      <= {WIDTH{1'b0}};
            acc_r         <= {(2*WIDTH){1'b0}};
            cnt_r         <= {CW{1'b0}};
            out_valid_r   <= 1'b0;
            out_product_r <= {(2*WIDTH){1'b0}};
`ifdef MUL_SIGNED_EN
            neg_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mcand_r  <= {{WIDTH{1'b0}}, load_a_s};
                        mplier_r <= load_b_s;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        cnt_r    <= {CW{1'b0}};
`ifdef MUL_SIGNED_EN
                        neg_r    <= load_neg_s;
`endif
                        state_r  <= BUSY;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    mcand_r  <= mcand_r << BITS_PER_CYCLE;
                    mplier_r <= mplier_r >> BITS_PER_CYCLE;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_STEP) begin
                        acc_r         <= final_s;
                        out_product_r <= final_s;
                        out_valid_r   <= 1'b1;
                        state_r       <= DONE;
                    end else begin
                        acc_r         <= acc_next_s;
                        state_r       <= BUSY;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r   <= 1'b0;
                        out_product_r <= {(2*WIDTH){1'b0}};
                        if (bus.in_valid) begin
                            mcand_r  <= {{WIDTH{1'b0}}, load_a_s};
                            mplier_r <= load_b_s;
                            acc_r    <= {(2*WIDTH){1'b0}};
                            cnt_r    <= {CW{1'b0}};
`ifdef MUL_SIGNED_EN
                            neg_r    <= load_neg_s;
`endif
                            state_r  <= BUSY;
                        end else begin
                            state_r  <= IDLE;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed self-checking bench for iterative_multiplier (honours MUL_SIGNED_EN).
module tb_iterative_multiplier;

    localparam int WIDTH = 32;
    localparam int BPC   = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    iterative_multiplier_if #(.WIDTH(WIDTH)) bus ();

    iterative_multiplier #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a     = 32'd0;
        bus.in_b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_product !== 64'd0) begin
            failures++; $display("FAIL reset_out_product got=%h exp=0", bus.out_product);
        end
    endtask

    task automatic test_basic();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL basic_idle_ready got=%b exp=1", bus.in_ready);
        end
        start_op(32'd3, 32'd5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy%0d in_ready=%b out_valid=%b exp 0/0", i, bus.in_ready, bus.out_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_product !== 64'd15) begin
            failures++;
            $display("FAIL basic_result valid=%b product=%h exp 1/%h", bus.out_valid, bus.out_product, 64'd15);
        end
        consume();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_after_take valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va   [7];
        logic [31:0] vb   [7];
        logic [63:0] vexp [7];
        int          lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
        va[1] = 32'h1234_5678; vb[1] = 32'h0000_0000;
        va[2] = 32'hFFFF_FFFD; vb[2] = 32'h0000_0007;
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000;
        va[4] = 32'h0000_0001; vb[4] = 32'h8000_0000;
        va[5] = 32'h0000_0000; vb[5] = 32'hFFFF_FFFF;
        va[6] = 32'h0000_0007; vb[6] = 32'hFFFF_FFFD;
`ifdef MUL_SIGNED_EN
        vexp[0] = 64'h0000_0000_0000_0001;
        vexp[2] = 64'hFFFF_FFFF_FFFF_FFEB;
        vexp[4] = 64'hFFFF_FFFF_8000_0000;
        vexp[6] = 64'hFFFF_FFFF_FFFF_FFEB;
`else
        vexp[0] = 64'hFFFF_FFFE_0000_0001;
        vexp[2] = 64'h0000_0006_FFFF_FFEB;
        vexp[4] = 64'h0000_0000_8000_0000;
        vexp[6] = 64'h0000_0006_FFFF_FFEB;
`endif
        vexp[1] = 64'd0;
        vexp[3] = 64'h4000_0000_0000_0000;
        vexp[5] = 64'd0;
        for (int i = 0; i < 7; i++) begin
            start_op(va[i], vb[i]);
            wait_valid(lat);
            checks++;
            if (lat !== 4) begin
                failures++; $display("FAIL vec%0d_latency got=%0d exp=4", i, lat);
            end
            checks++;
            if (bus.out_product !== vexp[i]) begin
                failures++; $display("FAIL vec%0d_product got=%h exp=%h", i, bus.out_product, vexp[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(32'd10, 32'd11);
        wait_valid(lat);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_product !== 64'd110) begin
                failures++;
                $display("FAIL hold%0d valid=%b product=%h exp 1/%h", i, bus.out_valid, bus.out_product, 64'd110);
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd2;
        bus.in_b      = 32'd9;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL done_pass_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL chained_busy valid=%b in_ready=%b exp 0/0", bus.out_valid, bus.in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 4 || bus.out_product !== 64'd18) begin
            failures++; $display("FAIL chained_result lat=%0d product=%h exp 4/%h", lat, bus.out_product, 64'd18);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta   [3];
        logic [31:0] tb   [3];
        logic [63:0] texp [3];
        int          tcyc [3];
        int          seen;
        ta[0] = 32'd7;      tb[0] = 32'd8;       texp[0] = 64'd56;
        ta[1] = 32'd100;    tb[1] = 32'd200;     texp[1] = 64'd20000;
        ta[2] = 32'h0000_FFFF; tb[2] = 32'h0001_0001; texp[2] = 64'h0000_0000_FFFF_FFFF;
        tcyc[0] = 4; tcyc[1] = 9; tcyc[2] = 14;
        seen = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = ta[0];
        bus.in_b      = tb[0];
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (seen > 2 || cyc != tcyc[seen] || bus.out_product !== texp[seen]) begin
                    failures++;
                    $display("FAIL b2b_result%0d cyc=%0d product=%h exp cyc=%0d product=%h",
                             seen, cyc, bus.out_product, tcyc[seen % 3], texp[seen % 3]);
                end
                seen++;
                if (seen < 3) begin
                    bus.in_a = ta[seen];
                    bus.in_b = tb[seen];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (seen != 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", seen);
        end
    endtask

    task automatic test_reset_mid_busy();
        int spurious;
        start_op(32'd6, 32'd7);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_product !== 64'd0) begin
            failures++;
            $display("FAIL midreset_state in_ready=%b valid=%b product=%h exp 1/0/0",
                     bus.in_ready, bus.out_valid, bus.out_product);
        end
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++; $display("FAIL midreset_no_result got=%0d valid cycles exp=0", spurious);
        end
    endtask

    task automatic test_soak();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_p;
        int          lat;
        for (int n = 0; n < 200; n++) begin
            a = $urandom();
            b = $urandom();
            if (n % 10 == 3) b = 32'd0;
            if (n % 10 == 7) a = 32'h8000_0000;
            exp_p = ref_mul(a, b);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            start_op(a, b);
            wait_valid(lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            checks++;
            if (bus.out_valid !== 1'b1 || lat !== 4 || bus.out_product !== exp_p) begin
                failures++;
                $display("FAIL soak%0d a=%h b=%h lat=%0d got=%h exp=%h", n, a, b, lat, bus.out_product, exp_p);
            end
            consume();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
